zion_rr_arb_reg: RTL
====================

ZION_RR_ARB_REG -- requirements
Module: zion_rr_arb_reg

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 8: width of each requester's data word.
REQ-003 Parameter INI_DATA, default '0: value of oDat after reset and after clear.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset; synchronous, active-high.
REQ-006 iClr  input  1: synchronous clear, active high.
REQ-007 iReqVld  input  NUM_REQ: per-requester valid; bit i belongs to requester i.
REQ-008 iReqDat  input  NUM_REQ*DATA_WIDTH: requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 oReqRdy  output  NUM_REQ: per-requester accept, combinational, at most one bit set.
REQ-010 oVld  output  1: output register holds a valid word.
REQ-011 oDat  output  DATA_WIDTH: registered winning data.
REQ-012 oGntId  output  $clog2(NUM_REQ): index of the requester whose word is in oDat.
REQ-013 iRdy  input  1: downstream accept of oDat.

Function
REQ-014 Load enable ld = !oVld | iRdy; with iClr=0 and rst=0, arbitration occurs only when ld=1.
REQ-015 Round-robin pointer ptr (range 0..NUM_REQ-1): winner = first i with iReqVld[i]=1, searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
REQ-016 oReqRdy[winner]=1 only when ld=1, iClr=0, rst=0 and at least one iReqVld bit is set; all other bits 0.
REQ-017 Transfer from requester i occurs in a cycle where iReqVld[i] & oReqRdy[i]; no other requester transfers in that cycle.
REQ-018 On transfer: next cycle oVld=1, oDat=requester's data, oGntId=i, ptr=(i+1) mod NUM_REQ; latency 1 cycle.
REQ-019 ld=1 and no iReqVld bit set: next cycle oVld=0, oDat and oGntId hold, ptr holds.
REQ-020 oVld=1 and iRdy=0: oVld, oDat, oGntId, ptr hold; oReqRdy all 0 (stall, no overwrite).
REQ-021 oVld=1, iRdy=1 and a request present: drain and new load in the same cycle; sustained throughput 1 word/cycle.
REQ-022 Fairness: with all requesters continuously valid and iRdy=1, grants cycle 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 transfers.
REQ-023 Wrap-around: winner NUM_REQ-1 sets ptr to 0.
REQ-024 iReqVld may drop without transfer; arbitration is re-evaluated every cycle from the same ptr (no grant lock).
REQ-025 iClr=1 (rst=0): oReqRdy all 0 that cycle; next cycle oVld=0, oDat=INI_DATA, oGntId=0, ptr=0; any word in oDat is discarded, even when iRdy=1.
REQ-026 iClr has priority over transfer and hold; rst has priority over iClr.
REQ-027 Elaboration check: NUM_REQ outside 2..16 or DATA_WIDTH<1 raises $error; $finish when CHECK_ERR_EXIT is defined.

Reset
REQ-028 rst=1 at a clock edge: next cycle oVld=0, oDat=INI_DATA, oGntId=0, ptr=0.
REQ-029 While rst=1, oReqRdy all 0 regardless of iReqVld.
REQ-030 Reset mid-stall discards the held word; first grant after reset release starts the search at requester 0.

Verification
REQ-031 NUM_REQ=4, DATA_WIDTH=8: reset, iReqVld=4'b1111, data i=8'hA0+i, iRdy=1 -> oGntId 0,1,2,3,0 on consecutive cycles, oDat A0,A1,A2,A3,A0, oVld=1 from the first cycle after the first grant.
REQ-032 After grant to requester 3 (ptr=0), iReqVld=4'b1010 -> requester 1 wins; next grant with same iReqVld -> requester 3.
REQ-033 oVld=1, oDat=8'h55, iRdy=0 for 5 cycles with iReqVld=4'b1111 -> oDat stays 8'h55, oReqRdy=0 throughout; iRdy=1 -> next word loaded that same cycle.
REQ-034 oVld=1, iClr=1 and iRdy=1 with iReqVld=4'b0100 -> oReqRdy=0, next cycle oVld=0, oDat=INI_DATA, oGntId=0; following cycle requester 2 granted.
REQ-035 rst=1 asserted during a stall with iClr=1 -> next cycle all outputs at reset values; after release, iReqVld=4'b1000 -> oGntId=3, then ptr=0.
REQ-036 Random iReqVld/iRdy/iClr for 10^5 cycles against a reference model -> exact match of oVld/oDat/oGntId, onehot0(oReqRdy), no word lost or duplicated outside clear/reset.

Source files
------------

// File: rtl/zion_rr_arb_reg.sv
// Round-robin arbiter feeding a single output register. Requesters are
// scanned from a rotating pointer, and the winner's word is registered with one cycle of latency.
module zion_rr_arb_reg #(
    parameter int                    NUM_REQ    = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INI_DATA   = '0,
    localparam int                   IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iClr,
    input  logic [NUM_REQ-1:0]            iReqVld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] iReqDat,
    output logic [NUM_REQ-1:0]            oReqRdy,
    output logic                          oVld,
    output logic [DATA_WIDTH-1:0]         oDat,
    output logic [IDW-1:0]                oGntId,
    input  logic                          iRdy
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16 || DATA_WIDTH < 1) begin : g_param_err
`ifdef CHECK_ERR_EXIT
            $fatal(1, "zion_rr_arb_reg: illegal NUM_REQ=%0d / DATA_WIDTH=%0d", NUM_REQ, DATA_WIDTH);
`else
            $error("zion_rr_arb_reg: illegal NUM_REQ=%0d / DATA_WIDTH=%0d", NUM_REQ, DATA_WIDTH);
`endif
        end
    endgenerate

    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [IDW-1:0]        gnt_q, gnt_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        win;
    logic                  ld, any_req, xfer;

    assign ld      = !vld_q | iRdy;
    assign any_req = |iReqVld;
    assign xfer    = ld & any_req & !iClr & !rst;

    // Scan downward in distance from ptr so the closest valid requester is written last and wins.
    always_comb begin
        int unsigned idx;
        win = '0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (iReqVld[idx]) win = IDW'(idx);
        end
    end

    assign oReqRdy = xfer ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        if (iClr) begin
            vld_d = 1'b0;
            dat_d = INI_DATA;
            gnt_d = '0;
            ptr_d = '0;
        end else if (ld) begin
            vld_d = any_req;
            if (any_req) begin
                dat_d = iReqDat[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                gnt_d = win;
                ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= INI_DATA;
            gnt_q <= '0;
            ptr_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign oVld   = vld_q;
    assign oDat   = dat_q;
    assign oGntId = gnt_q;

endmodule
